// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: AES SubBytes stage, LANES bytes per cycle.
// Captures a 128-bit state, substitutes it in N passes, then holds it downstream.
module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N = 16 / LANES;
  localparam int W = 8 * LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [3:0]   idx;
  logic [127:0] src_q;
  logic [127:0] res_q;
  logic [W-1:0] chunk_in;
  logic [W-1:0] chunk_out;
  logic         last;
  logic         accept;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = gmul(a, a);
    r = t;
    for (int i = 0; i < 6; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = res_q;
  assign last      = (idx == 4'(N - 1));
  assign chunk_in  = src_q[127 - int'(idx) * W -: W];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign chunk_out[W-1-8*l -: 8] = sbox(chunk_in[W-1-8*l -: 8]);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // capture source, then fill result LANES bytes per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 4'd0;
      src_q <= 128'd0;
      res_q <= 128'd0;
    end else begin
      unique case (1'b1)
        accept: begin
          src_q <= in_state;
          idx   <= 4'd0;
        end
        (state == RUN): begin
          res_q[127 - int'(idx) * W -: W] <= chunk_out;
          idx <= last ? 4'd0 : idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: directed + random checks of sub_bytes_serial
// for every legal LANES value against a table-based AES model.
module tb_sub_bytes_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]   iv, ir, ov, ordy, bz;
  logic [127:0] is [5];
  logic [127:0] os [5];

  for (genvar j = 0; j < 5; j++) begin : g_dut
    sub_bytes_serial #(.LANES(1 << j)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[j]),
      .in_ready (ir[j]),
      .in_state (is[j]),
      .out_valid(ov[j]),
      .out_ready(ordy[j]),
      .out_state(os[j]),
      .busy     (bz[j])
    );
  end

  int total = 0;
  int bad = 0;
  logic [7:0] sb [256];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // S-box table from generator-3 log/antilog tables plus bitwise affine map
  task automatic build_sbox();
    logic [7:0] pw [256];
    int lg [256];
    logic [7:0] x, inv, s;
    logic [7:0] c;
    c = 8'h63;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      pw[i] = x;
      lg[x] = i;
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
    for (int v = 0; v < 256; v++) begin
      if (v == 0) inv = 8'h00;
      else inv = pw[(255 - lg[v]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
             ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[v] = s;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[127 - 8*k -: 8] = sb[v[127 - 8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // send one state, scramble in_state during RUN, check latency/result
  task automatic run_one(input int d, input logic [127:0] v,
                         input string tag, input bit hold,
                         output logic [127:0] got);
    int lat;
    logic [127:0] exp;
    exp = model(v);
    @(negedge clk);
    chk({tag, "_in_ready"}, 128'(ir[d]), 128'd1);
    iv[d] = 1'b1;
    is[d] = v;
    @(negedge clk);
    iv[d] = 1'b0;
    is[d] = rnd128();
    lat = 0;
    while (!ov[d] && lat < 40) begin
      @(negedge clk);
      lat++;
      is[d] = rnd128();
    end
    chk({tag, "_latency"}, 128'(lat), 128'(16 >> d));
    chk({tag, "_data"}, os[d], exp);
    got = os[d];
    if (hold) begin
      for (int c = 0; c < 10; c++) begin
        iv[d] = 1'b1;
        is[d] = rnd128();
        @(negedge clk);
        chk({tag, "_hold_valid"}, 128'(ov[d]), 128'd1);
        chk({tag, "_hold_data"}, os[d], exp);
        chk({tag, "_hold_in_ready"}, 128'(ir[d]), 128'd0);
      end
      iv[d] = 1'b0;
    end
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    chk({tag, "_rel_valid"}, 128'(ov[d]), 128'd0);
    chk({tag, "_rel_in_ready"}, 128'(ir[d]), 128'd1);
    chk({tag, "_rel_busy"}, 128'(bz[d]), 128'd0);
  endtask

  // continuous traffic of alternating all-0 / all-1 states
  task automatic b2b(input int d);
    logic [127:0] q [$];
    logic [127:0] exp;
    int last_t, cyc, got, wt;
    bit pend;
    last_t = -1;
    cyc = 0;
    got = 0;
    pend = 1'b0;
    @(negedge clk);
    ordy[d] = 1'b1;
    iv[d] = 1'b1;
    is[d] = '0;
    while (got < 4 && cyc < 200) begin
      if (ov[d]) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        chk("b2b_data", os[d], exp);
        if (last_t >= 0)
          chk("b2b_period", 128'(cyc - last_t), 128'((16 >> d) + 2));
        last_t = cyc;
        got++;
      end
      if (ir[d]) begin
        q.push_back(model(is[d]));
        pend = 1'b1;
      end else if (pend) begin
        is[d] = ~is[d];
        pend = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", 128'(got), 128'd4);
    iv[d] = 1'b0;
    wt = 0;
    while (bz[d] && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    chk("b2b_drain", 128'(bz[d]), 128'd0);
    ordy[d] = 1'b0;
  endtask

  logic [127:0] res;
  logic [127:0] spot_in, spot_out, fips_in, fips_out;

  initial begin
    spot_in  = 128'h00010253_FF000000_00000000_00000000;
    spot_out = 128'h637C77ED_16636363_63636363_63636363;
    fips_in  = 128'h193DE3BE_A0F4E22B_9AC68D2A_E9F84808;
    fips_out = 128'hD42711AE_E0BF98F1_B8B45DE5_1E415230;
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    for (int j = 0; j < 5; j++) is[j] = '0;
    build_sbox();
    chk("model_s00", 128'(sb[8'h00]), 128'h63);
    chk("model_s01", 128'(sb[8'h01]), 128'h7c);
    chk("model_s53", 128'(sb[8'h53]), 128'hed);
    chk("model_sff", 128'(sb[8'hff]), 128'h16);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(ir[2]), 128'd0);
    chk("rst_out_valid", 128'(ov[2]), 128'd0);
    chk("rst_out_state", os[2], 128'd0);
    chk("rst_busy", 128'(bz), 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", 128'(ir), 128'h1f);

    run_one(2, spot_in, "spot", 1'b0, res);
    chk("spot_const", res, spot_out);

    for (int d = 0; d < 5; d++) begin
      run_one(d, fips_in, $sformatf("fips_l%0d", 1 << d), 1'b0, res);
      chk($sformatf("fips_const_l%0d", 1 << d), res, fips_out);
    end

    run_one(2, rnd128(), "bp", 1'b1, res);

    b2b(2);
    b2b(4);
    b2b(0);

    @(negedge clk);
    iv[2] = 1'b1;
    is[2] = rnd128();
    @(negedge clk);
    iv[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(ov[2]), 128'd0);
    chk("mid_rst_out_state", os[2], 128'd0);
    chk("mid_rst_busy", 128'(bz[2]), 128'd0);
    chk("mid_rst_in_ready", 128'(ir[2]), 128'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rel_in_ready", 128'(ir[2]), 128'd1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("mid_rst_no_output", 128'({ov[2], bz[2]}), 128'd0);
    end
    run_one(2, rnd128(), "after_rst", 1'b0, res);

    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 5; d++)
        run_one(d, rnd128(), $sformatf("rand_l%0d", 1 << d), 1'b0, res);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
